// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch-stage types
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  OP_HALT   = 5'b00000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bus
interface fetch_stage_if;

    logic        req;
    logic [15:0] addr;
    logic [15:0] data;
    logic        ready;

    modport master (
        output req,
        output addr,
        input  data,
        input  ready
    );

    modport slave (
        input  req,
        input  addr,
        output data,
        output ready
    );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, bubble and async reset
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [15:0] next_instr,
    input  logic [15:0] next_pc_inc,
    output logic [15:0] instr,
    output logic [15:0] pc_inc,
    output logic        valid
);

    // Bubble wins over load so a flush can never leak a real instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr  <= NOP_INSTR;
            pc_inc <= 16'h0000;
            valid  <= 1'b0;
        end else if (bubble) begin
            instr  <= NOP_INSTR;
            pc_inc <= 16'h0000;
            valid  <= 1'b0;
        end else if (load) begin
            instr  <= next_instr;
            pc_inc <= next_pc_inc;
            valid  <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, next-PC selection and fetch FSM feeding IF/ID
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_write,
    input  logic          if_id_write,
    input  logic          flush,
    input  logic [15:0]   branch_target,
    fetch_stage_if.master imem,
    output logic [15:0]   if_id_instr,
    output logic [15:0]   if_id_pc_inc,
    output logic          if_id_valid
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pc_next_seq;
    logic         ifid_load;
    logic         ifid_bubble;

    assign pc_next_seq = pc + 16'd2;
    assign imem.req    = (state == FETCH);
    assign imem.addr   = pc;

    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state)
            FETCH: begin
                if (flush)
                    ifid_bubble = 1'b1;
                else if (if_id_write) begin
                    if (imem.ready)
                        ifid_load = 1'b1;
                    else
                        ifid_bubble = 1'b1;
                end
            end
            HALT: begin
                if (flush || if_id_write)
                    ifid_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    // A fetched HALT is latched but freezes the PC until a flush redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (flush)
                        pc <= branch_target;
                    else if (if_id_write && imem.ready) begin
                        if (is_halt(imem.data))
                            state <= HALT;
                        else if (pc_write)
                            pc <= pc_next_seq;
                    end
                end
                HALT: begin
                    if (flush) begin
                        pc    <= branch_target;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .next_instr  (imem.data),
        .next_pc_inc (pc_next_seq),
        .instr       (if_id_instr),
        .pc_inc      (if_id_pc_inc),
        .valid       (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector table, corner sequences and random model check for fetch_stage
module tb_fetch_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, w_rst_n;
    logic        pc_write, if_id_write, flush;
    logic [15:0] branch_target;
    logic [15:0] if_id_instr, if_id_pc_inc;
    logic        if_id_valid;
    logic [15:0] w_instr, w_pc_inc;
    logic        w_valid;

    fetch_stage_if imem ();
    fetch_stage_if wimem ();

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
        .flush(flush), .branch_target(branch_target), .imem(imem.master),
        .if_id_instr(if_id_instr), .if_id_pc_inc(if_id_pc_inc), .if_id_valid(if_id_valid)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .pc_write(1'b1), .if_id_write(1'b1),
        .flush(1'b0), .branch_target(16'h0000), .imem(wimem.master),
        .if_id_instr(w_instr), .if_id_pc_inc(w_pc_inc), .if_id_valid(w_valid)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        pw, iw, fl;
        logic [15:0] bt;
        logic        rdy;
        logic        e_req;
        logic [15:0] e_addr, e_instr, e_inc;
        logic        e_valid;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic pw, input logic iw, input logic fl,
                                input logic [15:0] bt, input logic rdy,
                                input logic e_req, input logic [15:0] e_addr,
                                input logic [15:0] e_instr, input logic [15:0] e_inc,
                                input logic e_valid);
        vec_t v;
        v.pw = pw; v.iw = iw; v.fl = fl; v.bt = bt; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_inc = e_inc; v.e_valid = e_valid;
        return v;
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h0000 : 16'h4000 + a;
    endfunction

    task automatic check(input string name, input logic req, input logic [15:0] addr,
                         input logic [15:0] instr, input logic [15:0] inc, input logic valid);
        vectors++;
        if (imem.req !== req || imem.addr !== addr || if_id_instr !== instr ||
            if_id_pc_inc !== inc || if_id_valid !== valid) begin
            miscompares++;
            $display("FAIL %s: got req=%b addr=%h instr=%h pc_inc=%h valid=%b, want req=%b addr=%h instr=%h pc_inc=%h valid=%b",
                     name, imem.req, imem.addr, if_id_instr, if_id_pc_inc, if_id_valid,
                     req, addr, instr, inc, valid);
        end
    endtask

    task automatic check_w(input string name, input logic req, input logic [15:0] addr,
                           input logic [15:0] instr, input logic [15:0] inc, input logic valid);
        vectors++;
        if (wimem.req !== req || wimem.addr !== addr || w_instr !== instr ||
            w_pc_inc !== inc || w_valid !== valid) begin
            miscompares++;
            $display("FAIL %s: got req=%b addr=%h instr=%h pc_inc=%h valid=%b, want req=%b addr=%h instr=%h pc_inc=%h valid=%b",
                     name, wimem.req, wimem.addr, w_instr, w_pc_inc, w_valid,
                     req, addr, instr, inc, valid);
        end
    endtask

    task automatic drive(input logic pw, input logic iw, input logic fl,
                         input logic [15:0] bt, input logic rdy, input logic [15:0] data);
        pc_write      = pw;
        if_id_write   = iw;
        flush         = fl;
        branch_target = bt;
        imem.ready    = rdy;
        imem.data     = data;
        wimem.ready   = 1'b1;
        wimem.data    = mem_word(wimem.addr);
        @(posedge clk);
        #1;
    endtask

    // Reference model: program-order view of the fetch stage
    bit          m_started, m_halted;
    logic [15:0] m_pc, m_instr, m_inc;
    logic        m_valid;

    task automatic model_reset();
        m_started = 0; m_halted = 0; m_pc = 16'h0000;
        m_instr = 16'h0800; m_inc = 16'h0000; m_valid = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = 16'h0800; m_inc = 16'h0000; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic pw, input logic iw, input logic fl,
                              input logic [15:0] bt, input logic rdy, input logic [15:0] data);
        if (!m_started)
            m_started = 1;
        else if (fl) begin
            m_pc = bt; m_halted = 0; model_bubble();
        end else if (m_halted) begin
            if (iw) model_bubble();
        end else if (iw) begin
            if (!rdy)
                model_bubble();
            else begin
                m_instr = data;
                m_inc   = 16'((32'(m_pc) + 2) % 65536);
                m_valid = 1'b1;
                if (data[15:11] == 5'd0) m_halted = 1;
                else if (pw) m_pc = m_inc;
            end
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,16'h0000,16'h0800,16'h0000,1'b0);
        vecs[1]  = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,16'h0002,16'h4000,16'h0002,1'b1);
        vecs[2]  = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,16'h0004,16'h4002,16'h0004,1'b1);
        vecs[3]  = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,16'h0006,16'h4004,16'h0006,1'b1);
        vecs[4]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0006,16'h4004,16'h0006,1'b1);
        vecs[5]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0006,16'h4004,16'h0006,1'b1);
        vecs[6]  = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,16'h0008,16'h4006,16'h0008,1'b1);
        vecs[7]  = mk(1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b1,16'h0008,16'h0800,16'h0000,1'b0);
        vecs[8]  = mk(1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b1,16'h0008,16'h0800,16'h0000,1'b0);
        vecs[9]  = mk(1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b1,16'h0008,16'h0800,16'h0000,1'b0);
        vecs[10] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,16'h000A,16'h4008,16'h000A,1'b1);
        vecs[11] = mk(1'b1,1'b0,1'b1,16'h0040,1'b1, 1'b1,16'h0040,16'h0800,16'h0000,1'b0);
        vecs[12] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,16'h0042,16'h4040,16'h0042,1'b1);
        vecs[13] = mk(1'b1,1'b1,1'b1,16'h0010,1'b1, 1'b1,16'h0010,16'h0800,16'h0000,1'b0);
        vecs[14] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b0,16'h0010,16'h0000,16'h0012,1'b1);
        vecs[15] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'h0010,16'h0000,16'h0012,1'b1);
        vecs[16] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b0,16'h0010,16'h0800,16'h0000,1'b0);
        vecs[17] = mk(1'b1,1'b1,1'b1,16'h0020,1'b1, 1'b1,16'h0020,16'h0800,16'h0000,1'b0);
        vecs[18] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,16'h0022,16'h4020,16'h0022,1'b1);

        rst_n = 1'b0; w_rst_n = 1'b0;
        pc_write = 1'b1; if_id_write = 1'b1; flush = 1'b0; branch_target = 16'h0000;
        imem.ready = 1'b1; imem.data = 16'h4000;
        wimem.ready = 1'b1; wimem.data = 16'h4000;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0);
        check_w("wrap_reset", 1'b0, 16'hFFFE, 16'h0800, 16'h0000, 1'b0);
        rst_n = 1'b1; w_rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].bt, vecs[i].rdy, mem_word(imem.addr));
            check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                  vecs[i].e_instr, vecs[i].e_inc, vecs[i].e_valid);
            if (i == 0) check_w("wrap_idle", 1'b1, 16'hFFFE, 16'h0800, 16'h0000, 1'b0);
            if (i == 1) check_w("wrap_fetch", 1'b1, 16'h0000, 16'h3FFE, 16'h0000, 1'b1);
        end

        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold", 1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0);
        rst_n = 1'b1;
        model_reset();

        for (int n = 0; n < 600; n++) begin
            logic        pw, iw, fl, rdy;
            logic [15:0] bt, data;
            pw   = ($urandom_range(0, 99) < 85);
            iw   = ($urandom_range(0, 99) < 85);
            fl   = ($urandom_range(0, 99) < 10);
            rdy  = ($urandom_range(0, 99) < 80);
            bt   = 16'($urandom);
            data = 16'($urandom);
            if ($urandom_range(0, 11) == 0) data[15:11] = 5'd0;
            else if (data[15:11] == 5'd0) data[15] = 1'b1;
            drive(pw, iw, fl, bt, rdy, data);
            model_step(pw, iw, fl, bt, rdy, data);
            check($sformatf("rand%0d", n), m_started && !m_halted, m_pc, m_instr, m_inc, m_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
